// File: rtl/lane_pair_stim_check.sv
// Stimulus/response checker for a two-lane XOR datapath: drives LFSR-derived operands,
// compares the returned lanes after a fixed latency and reports error count / first failure.
module lane_pair_stim_check #(
    parameter int unsigned        LFSR_W      = 16,
    parameter logic [LFSR_W-1:0]  SEED        = LFSR_W'(16'hACE1),
    parameter logic [LFSR_W-1:0]  TAPS        = LFSR_W'(16'hB400),
    parameter int unsigned        NUM_VECTORS = 256,
    parameter int unsigned        LAT         = 0,
    parameter int unsigned        CNT_W       = 16,
    parameter int unsigned        IDX_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             u0,
    output logic             v0,
    output logic             u1,
    output logic             v1,
    input  logic             w0,
    input  logic             w1,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [IDX_W-1:0] first_err_idx
);

    localparam int unsigned DRAIN_W = 3;
    localparam int unsigned PIPE_W  = IDX_W + 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                start_acc;
    logic [LFSR_W-1:0]   lfsr_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DRAIN_W-1:0]  drain_q;
    logic [PIPE_W-1:0]   pipe_q [LAT+1];
    logic                last_vec;
    logic                drain_end;
    logic                mism;
    logic [PIPE_W-1:0]   cmp;
    logic [CNT_W-1:0]    err_d;
    logic [IDX_W-1:0]    first_d;

    assign last_vec  = (idx_q == IDX_W'(NUM_VECTORS - 1));
    assign drain_end = (drain_q == DRAIN_W'(LAT - 1));

    // Entry layout: {valid, vector index, exp1, exp0}; the last stage is the one compared.
    assign cmp  = pipe_q[LAT];
    assign mism = cmp[PIPE_W-1] && ({w1, w0} != cmp[1:0]);

    // Next-state logic; start is honoured in IDLE, or in DONE once done is visible.
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    start_acc = 1'b1;
                end
            end
            S_RUN: begin
                if (last_vec) begin
                    state_d = (LAT > 0) ? S_DRAIN : S_DONE;
                end
            end
            S_DRAIN: begin
                if (drain_end) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (start && done) begin
                    state_d   = S_RUN;
                    start_acc = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Result accumulation after this edge's compare.
    always_comb begin
        err_d   = err_count;
        first_d = first_err_idx;
        if (start_acc) begin
            err_d   = '0;
            first_d = '1;
        end else if (mism) begin
            if (err_count != '1) begin
                err_d = err_count + CNT_W'(1);
            end
            if (first_err_idx == '1) begin
                first_d = cmp[PIPE_W-2:2];
            end
        end
    end

    // Stimulus generation, compare delay line and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q        <= SEED;
            idx_q         <= '0;
            drain_q       <= '0;
            {v1, u1, v0, u0} <= 4'b0000;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '1;
            for (int unsigned i = 0; i <= LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            if (start_acc) begin
                lfsr_q <= SEED;
                idx_q  <= '0;
            end else if (state_q == S_RUN) begin
                lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
                idx_q  <= idx_q + IDX_W'(1);
                {v1, u1, v0, u0} <= lfsr_q[3:0];
            end
            drain_q <= (state_q == S_DRAIN) ? drain_q + DRAIN_W'(1) : '0;
            pipe_q[0] <= {(state_q == S_RUN), idx_q,
                          lfsr_q[2] ^ lfsr_q[3], lfsr_q[0] ^ lfsr_q[1]};
            for (int unsigned i = 1; i <= LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            busy          <= (state_q == S_RUN) || (state_q == S_DRAIN);
            done          <= (state_q == S_DONE) && !start_acc;
            pass          <= (state_q == S_DONE) && !start_acc && (err_d == '0);
            err_count     <= err_d;
            first_err_idx <= first_d;
        end
    end

endmodule

// File: tb/tb_lane_pair_stim_check.sv
// Bench for lane_pair_stim_check: behavioural DUT stand-ins around three checker instances,
// a scoreboard for the randomized runs and directed timing/saturation/reset checks.
module tb_lane_pair_stim_check;

    localparam int NA = 4;

    typedef struct {
        int kind;
        int err;
        int first;
        bit pass;
        int done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: LAT=0, NUM_VECTORS=4, stand-in DUT selectable at run time.
    logic start_a = 1'b0;
    logic u0_a, v0_a, u1_a, v1_a, w0_a, w1_a, busy_a, done_a, pass_a;
    logic [15:0] err_a, first_a;
    int   mode_a = 0;
    int   ka = 0;
    logic [1:0] flips [NA];
    logic [1:0] gold_a;
    logic [1:0] dly_a [2];
    logic [1:0] wa;

    assign gold_a = {u1_a ^ v1_a, u0_a ^ v0_a};
    always @(posedge clk) begin
        dly_a[0] <= gold_a;
        dly_a[1] <= dly_a[0];
    end
    always_comb begin
        int jj;
        logic [1:0] fl;
        jj = cyc - ka - 1;
        fl = (jj >= 0 && jj < NA) ? flips[jj[1:0]] : 2'b00;
        case (mode_a)
            0:       wa = gold_a ^ fl;
            1:       wa = {1'b0, gold_a[0]};
            default: wa = dly_a[1];
        endcase
    end
    assign {w1_a, w0_a} = wa;

    lane_pair_stim_check #(.NUM_VECTORS(4), .LAT(0)) u_a (
        .clk(clk), .rst(rst), .start(start_a),
        .u0(u0_a), .v0(v0_a), .u1(u1_a), .v1(v1_a), .w0(w0_a), .w1(w1_a),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .first_err_idx(first_a)
    );

    // Instance B: LAT=2 against a DUT registered through two flops.
    logic start_b = 1'b0;
    logic u0_b, v0_b, u1_b, v1_b, busy_b, done_b, pass_b;
    logic [1:0] db0, db1;
    logic [15:0] err_b, first_b;
    always @(posedge clk) begin
        db0 <= {u1_b ^ v1_b, u0_b ^ v0_b};
        db1 <= db0;
    end

    lane_pair_stim_check #(.NUM_VECTORS(4), .LAT(2)) u_b (
        .clk(clk), .rst(rst), .start(start_b),
        .u0(u0_b), .v0(v0_b), .u1(u1_b), .v1(v1_b), .w0(db1[0]), .w1(db1[1]),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .first_err_idx(first_b)
    );

    // Instance C: inverted DUT with a 2-bit saturating error counter.
    logic start_c = 1'b0;
    logic u0_c, v0_c, u1_c, v1_c, busy_c, done_c, pass_c;
    logic [1:0]  err_c;
    logic [15:0] first_c;

    lane_pair_stim_check #(.NUM_VECTORS(8), .LAT(0), .CNT_W(2)) u_c (
        .clk(clk), .rst(rst), .start(start_c),
        .u0(u0_c), .v0(v0_c), .u1(u1_c), .v1(v1_c),
        .w0(~(u0_c ^ v0_c)), .w1(~(u1_c ^ v1_c)),
        .busy(busy_c), .done(done_c), .pass(pass_c),
        .err_count(err_c), .first_err_idx(first_c)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    exp_t sb[$];
    logic done_prev = 1'b0;

    // Monitor: each rising done on instance A retires one scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (done_a && !done_prev) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("done_cycle", cyc, e.done_cyc);
                check("pass", pass_a, e.pass);
                if (e.kind == 0) begin
                    check("err_count", err_a, e.err);
                    check("first_err_idx", first_a, e.first);
                end else begin
                    check("err_nonzero", err_a != 0, 1);
                end
            end
        end
        done_prev <= done_a;
    end

    // One run on instance A: model the expected vectors and verdict, then drive and check operands.
    task automatic run_a(input int mode, input bit noise, input bit poke);
        exp_t e;
        logic [3:0]  nib [NA];
        logic [15:0] l;
        logic [1:0]  g, w;
        int k, cnt, poke_c, t;
        for (int j = 0; j < NA; j++) flips[j] = noise ? 2'($urandom_range(0, 3)) : 2'b00;
        mode_a = mode;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        ka = k;
        start_a = 1'b0;
        l = 16'hACE1;
        cnt = 0;
        e.first = 32'hFFFF;
        for (int j = 0; j < NA; j++) begin
            nib[j] = l[3:0];
            g = {l[3] ^ l[2], l[1] ^ l[0]};
            w = (mode == 0) ? (g ^ flips[j]) : (mode == 1) ? {1'b0, g[0]} : g;
            if (w != g) begin
                if (cnt == 0) e.first = j;
                cnt++;
            end
            l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
        end
        e.kind = (mode == 2) ? 1 : 0;
        e.err = cnt;
        e.pass = (mode == 2) ? 1'b0 : (cnt == 0);
        e.done_cyc = k + NA + 1;
        sb.push_back(e);
        check("start_clears_done", done_a, 0);
        check("start_clears_pass", pass_a, 0);
        check("start_clears_err", err_a, 0);
        check("start_clears_first", first_a, 16'hFFFF);
        poke_c = poke ? $urandom_range(k, k + NA - 2) : -1;
        for (int c = k; c <= k + NA; c++) begin
            @(negedge clk);
            if (c >= k + 1) check("operands", {v1_a, u1_a, v0_a, u0_a}, nib[c-k-1]);
            start_a = (c == poke_c);
        end
        start_a = 1'b0;
        t = 0;
        while (!done_a && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!done_a) check("done_timeout_a", 0, 1);
    endtask

    initial begin
        int k, t;
        #12;
        check("rst_ops", {v1_a, u1_a, v0_a, u0_a}, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_pass", pass_a, 0);
        check("rst_err", err_a, 0);
        check("rst_first", first_a, 16'hFFFF);
        @(negedge clk);
        rst = 1'b0;

        run_a(0, 1'b0, 1'b0);
        run_a(1, 1'b0, 1'b0);
        run_a(2, 1'b0, 1'b0);

        // LAT=2 timing: busy k+1..k+6, done from k+7.
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        start_b = 1'b0;
        for (int c = k; c <= k + 8; c++) begin
            @(negedge clk);
            check("b_busy", busy_b, (c >= k + 1 && c <= k + 6));
            check("b_done", done_b, (c >= k + 7));
        end
        check("b_pass", pass_b, 1);
        check("b_err", err_b, 0);

        // Saturation with an always-wrong DUT.
        @(negedge clk);
        start_c = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        start_c = 1'b0;
        t = 0;
        while (!done_c && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("c_done_cycle", cyc, k + 9);
        check("c_err_sat", err_c, 3);
        check("c_first", first_c, 0);
        check("c_pass", pass_c, 0);

        for (int i = 0; i < 14; i++) run_a(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Asynchronous reset in the middle of a run.
        for (int j = 0; j < NA; j++) flips[j] = 2'b00;
        mode_a = 0;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        ka = k;
        start_a = 1'b0;
        while (cyc < k + 2) @(posedge clk);
        #1;
        check("midrun_busy", busy_a, 1);
        rst = 1'b1;
        #1;
        check("mrst_ops", {v1_a, u1_a, v0_a, u0_a}, 0);
        check("mrst_busy", busy_a, 0);
        check("mrst_done", done_a, 0);
        check("mrst_err", err_a, 0);
        check("mrst_first", first_a, 16'hFFFF);
        @(negedge clk);
        rst = 1'b0;
        run_a(0, 1'b0, 1'b0);
        run_a(0, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lane_pair_stim_check.md
Name: lane_pair_stim_check

Overview:
- Self-checking stimulus/response stage for a two-lane XOR datapath; DUT lane i computes wi = ui ^ vi.
- Generates pseudo-random lane operands from a Galois LFSR and drives u0/v0/u1/v1 into the DUT.
- Consumes w0/w1 after a fixed DUT latency and compares them against internally computed expected values.
- Reports an error count, the index of the first failing vector, and a pass/done status.

Parameters:
- LFSR_W, 16, LFSR width (>=4).
- SEED, 16'hACE1, LFSR load value on each start; must be nonzero.
- TAPS, 16'hB400, Galois feedback mask.
- NUM_VECTORS, 256, vectors per run (>=1).
- LAT, 0, DUT response latency in clock cycles (0..7).
- CNT_W, 16, width of err_count.
- IDX_W, 16, width of first_err_idx and the internal vector index.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  run request; sampled in IDLE or DONE.
- u0  out  1  lane 0 operand a (registered).
- v0  out  1  lane 0 operand b (registered).
- u1  out  1  lane 1 operand a (registered).
- v1  out  1  lane 1 operand b (registered).
- w0  in  1  lane 0 DUT result.
- w1  in  1  lane 1 DUT result.
- busy  out  1  high while in RUN or DRAIN.
- done  out  1  high in DONE.
- pass  out  1  in DONE: 1 iff err_count==0; 0 elsewhere.
- err_count  out  CNT_W  number of mismatched vectors; saturating.
- first_err_idx  out  IDX_W  index of first mismatched vector; all-ones if none.

Behaviour:
- Reset values:
  - u0, v0, u1, v1, busy, done, pass = 0; err_count = 0; first_err_idx = all-ones.
  - FSM = IDLE; LFSR = SEED; index = 0; compare pipeline cleared.
- LFSR step: next = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 0).
- Operand mapping from the current LFSR value: u0=lfsr[0], v0=lfsr[1], u1=lfsr[2], v1=lfsr[3].
- FSM states:
  - IDLE: start=1 at edge k -> RUN. LFSR = SEED, index = 0, err_count = 0, first_err_idx = all-ones.
  - RUN: at each edge, the operand registers load the current LFSR bits, the LFSR steps, and the index increments.
    - Vector j appears on the outputs during cycle k+1+j.
    - After the edge that loads vector NUM_VECTORS-1: go to DRAIN if LAT>0, else DONE.
  - DRAIN: counts LAT cycles, then goes to DONE. Operands hold their last value.
  - DONE: done=1 and pass valid. start=1 restarts exactly as from IDLE and clears done and pass at that edge.
- start is ignored in RUN and DRAIN.
- Compare pipeline:
  - A LAT-deep delay line carries {valid, j, exp1 = u1^v1, exp0 = u0^v0} of each driven vector.
  - At each edge where the delayed valid=1, compare {w1, w0} against {exp1, exp0}.
  - LAT=0 compares in the same cycle the vector is driven.
- On a mismatch (either lane, counted once per vector):
  - err_count += 1, saturating at 2^CNT_W-1.
  - If first_err_idx is all-ones, capture j.
- w0/w1 are ignored whenever no valid compare is pending (IDLE, DONE, post-reset).
- Timing for a start sampled at edge k:
  - busy = 1 in cycles k+1 .. k+NUM_VECTORS+LAT.
  - done rises in cycle k+NUM_VECTORS+LAT+1.
  - The last compare happens at the edge entering DONE.
- Reset mid-run: all state returns to reset values immediately (asynchronous), and in-flight compares are discarded. The next start reproduces the identical vector sequence from SEED.
- Index width: the index counts 0..NUM_VECTORS-1; IDX_W must hold NUM_VECTORS-1.

Test Plan:
- Golden DUT, combinational (w=u^v), LAT=0, NUM_VECTORS=4, start at edge k:
  - Operands {v1,u1,v0,u0}: 0001, 0000, 1000, 1100 (LFSR 0xACE1, 0xE270, 0x7138, 0x389C).
  - Required: done in cycle k+5, pass=1, err_count=0, first_err_idx=16'hFFFF.
- DUT with w1 stuck at 0, same setup:
  - Only vector 2 mismatches (expected w1=1).
  - Required: err_count=1, first_err_idx=2, pass=0.
- Golden DUT registered through 2 flops, LAT=2, NUM_VECTORS=4:
  - Required: busy high in cycles k+1..k+6, done in cycle k+7, pass=1.
  - Same DUT with LAT=0 -> err_count>0.
- Inverted DUT (w=~(u^v)), CNT_W=2, NUM_VECTORS=8:
  - Required: err_count saturates at 3, first_err_idx=0, pass=0.
- Reset mid-run:
  - Assert rst in cycle k+2 -> all outputs at reset values in the same cycle.
  - Re-start -> vector 0 is again 0001, and the run completes with pass=1.
- Handshake:
  - start pulsed during RUN -> no effect, done timing unchanged.
  - start in DONE -> done/pass drop at that edge, err_count clears, a new run begins.
